instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Instruction source for the register-bank datapath top: holds a small program memory and issues 16-bit instructions one at a time to the core under a valid/ready handshake.
- Replaces bench-driven instruction pokes with an in-design fetch engine.
- Program memory is loaded through a write port while idle.
- Two opcodes are consumed locally and never issued: jump (4'hE) and halt (4'hF).

Parameters:
INSTR_W, 16, instruction width
ADDR_W, 4, program address width
DEPTH, 16, program memory entries (= 2**ADDR_W)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
load_en  input  1  write load_data into mem[load_addr]; honoured only in IDLE or DONE
load_addr  input  ADDR_W  program write address
load_data  input  INSTR_W  program write data
start  input  1  begin execution from address 0; honoured only in IDLE or DONE
instr_out  output  INSTR_W  instruction presented to core
instr_valid  output  1  instr_out is valid
instr_ready  input  1  core accepts instr_out this cycle
pc  output  ADDR_W  current program counter
busy  output  1  high in FETCH or ISSUE
done  output  1  high in DONE

Behaviour:
- Reset (rst=0, any time, including mid-run):
  - state=IDLE, pc=0, instruction register=0.
  - Outputs: instr_out=0, instr_valid=0, busy=0, done=0.
  - Memory contents are not cleared.
- Memory: DEPTH x INSTR_W. Synchronous write. Read is registered into the instruction register during FETCH.
- States and transitions:
  - IDLE: on start, go to FETCH with pc<=0. load_en is accepted. If start and load_en arrive in the same cycle, the write completes and is visible to the first fetch.
  - FETCH: ir<=mem[pc], then go to ISSUE. Lasts exactly 1 cycle.
  - ISSUE, ir[15:12]==4'hF (halt): go to DONE. instr_valid stays 0. pc holds the halt address.
  - ISSUE, ir[15:12]==4'hE (jump): pc<=ir[ADDR_W-1:0], go to FETCH. instr_valid stays 0.
  - ISSUE, any other opcode: instr_valid=1, instr_out=ir. Hold until instr_ready=1. On the handshake cycle: pc<=pc+1, go to FETCH.
  - DONE: done=1. start goes to FETCH with pc<=0. load_en is accepted.
- instr_valid = (state==ISSUE) && opcode not in {E,F}. It is decoded only from registered state, with no combinational path from instr_ready.
- instr_out equals the instruction register at all times, and is stable while instr_valid=1 and instr_ready=0.
- Timing:
  - Latency from start sampled to first instr_valid: 2 cycles.
  - Peak throughput: 1 instruction per 2 cycles.
  - Jump adds 2 cycles with no issue.
- Wrap-around: pc is ADDR_W bits, so pc+1 from DEPTH-1 wraps to 0 with no error.
- Ignored inputs:
  - start during FETCH/ISSUE has no effect.
  - load_en during FETCH/ISSUE has no effect; memory is unchanged.
- instr_ready while instr_valid=0 is ignored.
- A jump-to-self program loops forever. Only reset exits it.

Test Plan:
- Load mem[0..3]={1234,5120,1111,F000}, start, instr_ready=1 -> instr_valid high 2 cycles after start. Issue order 1234,5120,1111, each valid for exactly 1 cycle, 1 idle cycle between. Then done=1, pc=3, busy=0.
- Same program, instr_ready=0 for 5 cycles on the second instruction -> instr_out holds 5120 with valid=1 throughout. Accepted on the first ready cycle. pc goes 1->2 only then.
- mem[0]=2522, mem[1]=E005, mem[5]=0000, mem[6]=F000 -> issued 2522 then 0000. E005 never appears with valid=1. pc passes 1->5->6. done=1.
- Fill all 16 entries with 1111 except mem[2]=F000; set mem[15]=0001, start at DONE after a first run -> restarts at pc=0. Separately, a program with no halt in 0..15 wraps from pc=15 to pc=0.
- Pull rst low while instr_valid=1 mid-run -> all outputs 0 immediately (asynchronous). After release, memory is intact and start replays from address 0.
- Assert load_en with load_addr=0, data=FFFF during ISSUE -> mem[0] unchanged, verified by a rerun. Start pulsed while busy -> no restart, pc unaffected.

Source files
------------

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Instruction issue handshake between the sequencer (master)
//               and the consuming core (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr_out,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_out,
    input  instr_valid,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Small program memory plus fetch engine. Issues instructions
//               one at a time over a valid/ready handshake; jump (E) and
//               halt (F) opcodes are consumed locally and never issued.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16
) (
  input  logic                clk,
  input  logic                rst,        // asynchronous, active-low
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [INSTR_W-1:0]  load_data,
  input  logic                start,
  instr_sequencer_if.master   bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] OP_JUMP = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic               w_stopped;
  logic [3:0]         w_ir_op;
  logic [3:0]         w_fetch_op;

  // Loading and starting are only honoured while the engine is not running.
  assign w_stopped  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign w_ir_op    = ir_q[INSTR_W-1 -: 4];
  assign w_fetch_op = mem_q[pc_q][INSTR_W-1 -: 4];

  // Program memory write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (load_en && w_stopped) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Fetch/issue state machine with registered valid/busy/done outputs.
  // valid is decided at fetch time from the opcode being loaded, so it never
  // depends combinationally on instr_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_q    <= mem_q[pc_q];
          valid_q <= (w_fetch_op != OP_JUMP) && (w_fetch_op != OP_HALT);
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_ir_op == OP_HALT) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (w_ir_op == OP_JUMP) begin
            pc_q    <= ir_q[ADDR_W-1:0];
            state_q <= S_FETCH;
          end else if (bus.instr_ready) begin
            pc_q    <= pc_q + 1'b1;   // wraps naturally at DEPTH-1
            valid_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_out   = ir_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer: directed scenarios
//               plus random programs checked against a program-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] model_mem [16];
  logic [15:0] exp_q [$];
  logic [3:0]  exp_pc;
  logic [15:0] got_q [$];
  logic [3:0]  pc_tr [$];
  bit          bad_seen;

  instr_sequencer_if #(.INSTR_W(16)) bus ();

  instr_sequencer #(.INSTR_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .bus       (bus),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Program-level model: walk the program from address 0 following opcode rules.
  task automatic model_exec(output bit halts);
    int p;
    logic [15:0] w;
    p = 0; halts = 1'b0; exp_q.delete(); exp_pc = '0;
    for (int s = 0; s < 200; s++) begin
      w = model_mem[p];
      if (w[15:12] == 4'hF) begin
        halts = 1'b1; exp_pc = 4'(p); return;
      end else if (w[15:12] == 4'hE) begin
        p = int'(w[3:0]);
      end else begin
        exp_q.push_back(w);
        p = (p + 1) % 16;
      end
    end
  endtask

  // Run until done (or budget), recording accepted instructions and pc changes.
  task automatic run_prog(input bit rand_ready, input int budget,
                          input bit with_start, output bit fin);
    got_q.delete(); pc_tr.delete(); bad_seen = 1'b0; fin = 1'b0;
    if (with_start) do_start();
    pc_tr.push_back(pc);
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin fin = 1'b1; break; end
      bus.instr_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      if (bus.instr_valid === 1'b1 && bus.instr_out[15:13] === 3'b111) bad_seen = 1'b1;
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) got_q.push_back(bus.instr_out);
      tick();
      if (pc !== pc_tr[$]) pc_tr.push_back(pc);
    end
    if (done === 1'b1) fin = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.instr_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bus.instr_out, bus.instr_valid, busy, done, pc} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got out=%h v=%b busy=%b done=%b pc=%0d, want all 0",
               bus.instr_out, bus.instr_valid, busy, done, pc);
    end
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.instr_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: got v=%b busy=%b done=%b, want 000",
               bus.instr_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  vtrace;
    logic [15:0] outs [$];
    load_word(4'd0, 16'h1234); load_word(4'd1, 16'h5120);
    load_word(4'd2, 16'h1111); load_word(4'd3, 16'hF000);
    bus.instr_ready = 1'b1;
    do_start();
    vtrace = '0;
    for (int k = 0; k < 8; k++) begin
      vtrace[k] = bus.instr_valid;
      if (bus.instr_valid === 1'b1) outs.push_back(bus.instr_out);
      tick();
    end
    n_cmp++;
    if (vtrace !== 8'b0010_1010) begin
      n_err++;
      $display("FAIL basic_valid_timing: got trace=%b, want 00101010", vtrace);
    end
    n_cmp++;
    if (outs.size() != 3 || outs[0] !== 16'h1234 || outs[1] !== 16'h5120 || outs[2] !== 16'h1111) begin
      n_err++;
      $display("FAIL basic_issue_order: got %0d issued (first %h), want 1234,5120,1111",
               outs.size(), outs.size() > 0 ? outs[0] : 16'hxxxx);
    end
    n_cmp++;
    if ({done, busy, pc} !== {1'b1, 1'b0, 4'd3}) begin
      n_err++;
      $display("FAIL basic_done_state: got done=%b busy=%b pc=%0d, want 1 0 3", done, busy, pc);
    end
  endtask

  task automatic test_stall();
    bit fin;
    bus.instr_ready = 1'b1;
    do_start();
    for (int c = 0; c < 8 && bus.instr_valid !== 1'b1; c++) tick();
    n_cmp++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h1234) begin
      n_err++;
      $display("FAIL stall_first: got v=%b out=%h, want 1 1234", bus.instr_valid, bus.instr_out);
    end
    tick();
    bus.instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.instr_valid, bus.instr_out, pc} !== {1'b1, 16'h5120, 4'd1}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b out=%h pc=%0d, want 1 5120 1",
                 i, bus.instr_valid, bus.instr_out, pc);
      end
      tick();
    end
    bus.instr_ready = 1'b1;
    n_cmp++;
    if ({bus.instr_valid, bus.instr_out, pc} !== {1'b1, 16'h5120, 4'd1}) begin
      n_err++;
      $display("FAIL stall_release: got v=%b out=%h pc=%0d, want 1 5120 1",
               bus.instr_valid, bus.instr_out, pc);
    end
    tick();
    n_cmp++;
    if ({bus.instr_valid, pc} !== {1'b0, 4'd2}) begin
      n_err++;
      $display("FAIL stall_advance: got v=%b pc=%0d, want 0 2", bus.instr_valid, pc);
    end
    run_prog(1'b0, 20, 1'b0, fin);
    n_cmp++;
    if (!fin || got_q.size() != 1 || got_q[0] !== 16'h1111) begin
      n_err++;
      $display("FAIL stall_finish: got fin=%b issued=%0d, want done after 1111", fin, got_q.size());
    end
  endtask

  task automatic test_jump();
    bit fin;
    load_word(4'd0, 16'h2522); load_word(4'd1, 16'hE005);
    load_word(4'd5, 16'h0000); load_word(4'd6, 16'hF000);
    run_prog(1'b0, 40, 1'b1, fin);
    n_cmp++;
    if (!fin || got_q.size() != 2 || got_q[0] !== 16'h2522 || got_q[1] !== 16'h0000) begin
      n_err++;
      $display("FAIL jump_issue: got fin=%b issued=%0d, want 2522,0000", fin, got_q.size());
    end
    n_cmp++;
    if (bad_seen) begin
      n_err++;
      $display("FAIL jump_not_issued: got E/F opcode with valid=1, want never");
    end
    n_cmp++;
    if (pc_tr.size() != 4 || pc_tr[0] !== 4'd0 || pc_tr[1] !== 4'd1 || pc_tr[2] !== 4'd5 || pc_tr[3] !== 4'd6) begin
      n_err++;
      $display("FAIL jump_pc_path: got %0d pc steps (last %0d), want 0,1,5,6", pc_tr.size(), pc_tr[$]);
    end
  endtask

  task automatic test_restart_wrap();
    bit fin;
    bit wrapped;
    int n7;
    for (int a = 0; a < 16; a++) load_word(4'(a), 16'h1111);
    load_word(4'd2, 16'hF000);
    load_word(4'd15, 16'h0001);
    for (int r = 0; r < 2; r++) begin
      run_prog(1'b0, 30, 1'b1, fin);
      n_cmp++;
      if (!fin || pc_tr[0] !== 4'd0 || got_q.size() != 2 || pc !== 4'd2) begin
        n_err++;
        $display("FAIL restart_run[%0d]: got fin=%b pc0=%0d issued=%0d pc=%0d, want 1 0 2 2",
                 r, fin, pc_tr[0], got_q.size(), pc);
      end
    end
    load_word(4'd0, 16'hE00F);
    load_word(4'd15, 16'h7777);
    run_prog(1'b0, 30, 1'b1, fin);
    wrapped = 1'b0; n7 = 0;
    for (int i = 0; i + 1 < pc_tr.size(); i++)
      if (pc_tr[i] == 4'd15 && pc_tr[i+1] == 4'd0) wrapped = 1'b1;
    foreach (got_q[i]) if (got_q[i] == 16'h7777) n7++;
    n_cmp++;
    if (fin || !wrapped || n7 < 2 || n7 != got_q.size()) begin
      n_err++;
      $display("FAIL wrap_loop: got fin=%b wrapped=%b n7777=%0d issued=%0d, want 0 1 >=2 all",
               fin, wrapped, n7, got_q.size());
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({busy, done, bus.instr_valid, pc} !== 7'd0) begin
      n_err++;
      $display("FAIL wrap_exit_reset: got busy=%b done=%b v=%b pc=%0d, want 0", busy, done, bus.instr_valid, pc);
    end
  endtask

  task automatic test_reset_mid();
    bit fin, h;
    load_word(4'd0, 16'h1234); load_word(4'd1, 16'h5120);
    load_word(4'd2, 16'h1111); load_word(4'd3, 16'hF000);
    bus.instr_ready = 1'b0;
    do_start();
    for (int c = 0; c < 8 && bus.instr_valid !== 1'b1; c++) tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.instr_out, bus.instr_valid, busy, done, pc} !== 23'd0) begin
      n_err++;
      $display("FAIL async_reset: got out=%h v=%b busy=%b done=%b pc=%0d, want all 0",
               bus.instr_out, bus.instr_valid, busy, done, pc);
    end
    tick();
    rst = 1'b1;
    run_prog(1'b1, 60, 1'b1, fin);
    model_exec(h);
    n_cmp++;
    if (!fin || got_q != exp_q || pc !== exp_pc) begin
      n_err++;
      $display("FAIL reset_replay: got fin=%b issued=%0d pc=%0d, want 1 %0d %0d",
               fin, got_q.size(), pc, exp_q.size(), exp_pc);
    end
  endtask

  task automatic test_ignored();
    bit fin, h;
    bus.instr_ready = 1'b0;
    do_start();
    for (int c = 0; c < 8 && bus.instr_valid !== 1'b1; c++) tick();
    load_en = 1'b1; load_addr = 4'd0; load_data = 16'hFFFF; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.instr_valid, bus.instr_out, pc, busy} !== {1'b1, 16'h1234, 4'd0, 1'b1}) begin
        n_err++;
        $display("FAIL busy_ignore[%0d]: got v=%b out=%h pc=%0d busy=%b, want 1 1234 0 1",
                 i, bus.instr_valid, bus.instr_out, pc, busy);
      end
    end
    bus.instr_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.instr_out, pc} !== {16'h5120, 4'd1}) begin
      n_err++;
      $display("FAIL start_ignored: got out=%h pc=%0d, want 5120 1", bus.instr_out, pc);
    end
    load_en = 1'b0; start = 1'b0;
    run_prog(1'b0, 30, 1'b0, fin);
    run_prog(1'b0, 30, 1'b1, fin);
    model_exec(h);
    n_cmp++;
    if (!fin || got_q.size() == 0 || got_q[0] !== 16'h1234 || got_q != exp_q) begin
      n_err++;
      $display("FAIL load_ignored: got fin=%b first=%h issued=%0d, want 1 1234 %0d",
               fin, got_q.size() > 0 ? got_q[0] : 16'hxxxx, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_same_cycle();
    bit fin, h;
    load_en = 1'b1; load_addr = 4'd0; load_data = 16'hABCD; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    model_mem[0] = 16'hABCD;
    run_prog(1'b0, 30, 1'b0, fin);
    model_exec(h);
    n_cmp++;
    if (!fin || got_q.size() == 0 || got_q[0] !== 16'hABCD || got_q != exp_q) begin
      n_err++;
      $display("FAIL load_with_start: got fin=%b first=%h, want 1 abcd",
               fin, got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    bit fin, h;
    int r;
    logic [15:0] w [16];
    for (int it = 0; it < 15; it++) begin
      h = 1'b0;
      while (!h) begin
        for (int a = 0; a < 16; a++) begin
          r = int'($urandom_range(15));
          if (r < 2)      w[a] = {4'hF, 12'($urandom)};
          else if (r < 4) w[a] = {4'hE, 12'($urandom)};
          else            w[a] = {4'($urandom_range(13)), 12'($urandom)};
          model_mem[a] = w[a];
        end
        model_exec(h);
      end
      for (int a = 0; a < 16; a++) load_word(4'(a), w[a]);
      model_exec(h);
      run_prog(1'b1, 1500, 1'b1, fin);
      n_cmp++;
      if (!fin || bad_seen || got_q != exp_q || pc !== exp_pc || busy !== 1'b0) begin
        n_err++;
        $display("FAIL random[%0d]: got fin=%b bad=%b issued=%0d pc=%0d busy=%b, want 1 0 %0d %0d 0",
                 it, fin, bad_seen, got_q.size(), pc, busy, exp_q.size(), exp_pc);
      end
    end
  endtask

  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_jump();
    test_restart_wrap();
    test_reset_mid();
    test_ignored();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
